// File: rtl/dmem_responder_if.sv
// Data-memory port bundle: request handshake (requester -> responder) and
// response handshake (responder -> requester).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one access at a time, WAIT_CYCLES wait states.
// Define DMEM_BYTE_OPS_EN to enable sign-extended byte loads and byte-lane stores.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    dmem_responder_if.slave bus,
    output logic [15:0]     access_count
);
    localparam int         WORDS     = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0] mem [WORDS];

    logic        write_p0;
    logic [17:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wait_cnt_p0;

    logic                  accept, execute, rsp_done;
    logic                  exec_write, exec_in_range;
    logic [17:0]           exec_addr;
    logic [31:0]           exec_wdata, mem_word, load_data, store_data;
    logic [DEPTH_LOG2-1:0] exec_idx;

`ifdef DMEM_BYTE_OPS_EN
    logic byte_p0;
    logic exec_byte;

    function automatic logic [31:0] sext_byte(input logic signed [7:0] b);
        logic signed [31:0] w;
        w = b;
        return w;
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] old_word, input logic [7:0] b);
        return {old_word[31:8], b};
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        execute   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (ZERO_WAIT) begin
                        execute   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_p0 == 4'd1) begin
                    execute   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = reset_n && (state == IDLE);

    // p0: request capture at the accept edge
    always_ff @(posedge clock) begin
        if (accept) begin
            write_p0 <= bus.req_write;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
`ifdef DMEM_BYTE_OPS_EN
            byte_p0  <= bus.req_byte;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)             wait_cnt_p0 <= 4'd0;
        else if (accept)          wait_cnt_p0 <= WAIT_LOAD;
        else if (state == WAIT)   wait_cnt_p0 <= wait_cnt_p0 - 4'd1;
    end

    // With no wait states the access executes on the accept edge itself,
    // before the capture registers hold the request.
    assign exec_write    = ZERO_WAIT ? bus.req_write : write_p0;
    assign exec_addr     = ZERO_WAIT ? bus.req_addr  : addr_p0;
    assign exec_wdata    = ZERO_WAIT ? bus.req_wdata : wdata_p0;
    assign exec_in_range = ({1'b0, exec_addr} < 19'(WORDS));
    assign exec_idx      = exec_addr[DEPTH_LOG2-1:0];
    assign mem_word      = mem[exec_idx];

`ifdef DMEM_BYTE_OPS_EN
    assign exec_byte  = ZERO_WAIT ? bus.req_byte : byte_p0;
    assign load_data  = exec_byte ? sext_byte(mem_word[7:0]) : mem_word;
    assign store_data = exec_byte ? merge_byte(mem_word, exec_wdata[7:0]) : exec_wdata;
`else
    logic unused_req_byte;
    assign unused_req_byte = bus.req_byte;
    assign load_data  = mem_word;
    assign store_data = exec_wdata;
`endif

    // p1: execute edge -- memory update and response registers
    always_ff @(posedge clock) begin
        if (reset_n && execute && exec_write && exec_in_range)
            mem[exec_idx] <= store_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            access_count  <= 16'd0;
        end else if (execute) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= !exec_in_range;
            bus.rsp_rdata <= (exec_in_range && !exec_write) ? load_data : 32'd0;
        end else if (rsp_done) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            access_count  <= access_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instances with 2, 0 and 4 wait states share clock and reset;
// expected responses are queued when a request is driven and compared when it returns.
module tb_dmem_responder;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic        req_valid   [3];
    logic        req_write   [3];
    logic        req_byte    [3];
    logic [17:0] req_addr    [3];
    logic [31:0] req_wdata   [3];
    logic        rsp_ready   [3];
    logic        req_ready_o [3];
    logic        rsp_valid_o [3];
    logic [31:0] rsp_rdata_o [3];
    logic        rsp_err_o   [3];
    logic [15:0] count_o     [3];

    exp_t        exp_q[$];
    logic [15:0] exp_cnt [3];
    int          errors = 0;
    int          checks = 0;

    // instance 0: 2 wait states, 1: none, 2: four
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder_if bus ();
        assign bus.req_valid  = req_valid[g];
        assign bus.req_write  = req_write[g];
        assign bus.req_byte   = req_byte[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.rsp_ready  = rsp_ready[g];
        assign req_ready_o[g] = bus.req_ready;
        assign rsp_valid_o[g] = bus.rsp_valid;
        assign rsp_rdata_o[g] = bus.rsp_rdata;
        assign rsp_err_o[g]   = bus.rsp_err;

        dmem_responder #(
            .DEPTH_LOG2  (10),
            .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 0 : 4))
        ) u_dut (
            .clock        (clock),
            .reset_n      (reset_n),
            .bus          (bus),
            .access_count (count_o[g])
        );
    end

    task automatic send_req(input int k, input logic w, input logic b, input logic [17:0] a,
                            input logic [31:0] d, output int acc_cyc, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        acc_cyc = -1;
        @(negedge clock);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_byte[k]  = b;
        req_addr[k]  = a;
        req_wdata[k] = d;
        while (!req_ready_o[k] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (req_ready_o[k]) begin
            ok = 1'b1;
            acc_cyc = cyc;
        end
        @(negedge clock);
        req_valid[k] = 1'b0;
    endtask

    task automatic recv_rsp(input int k, output int rv_cyc, output logic [31:0] rd,
                            output logic er, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        rv_cyc = -1;
        rd = 32'hxxxxxxxx;
        er = 1'bx;
        while (!rsp_valid_o[k] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (rsp_valid_o[k]) begin
            ok = 1'b1;
            rv_cyc = cyc;
            rd = rsp_rdata_o[k];
            er = rsp_err_o[k];
            rsp_ready[k] = 1'b1;
            @(negedge clock);
            rsp_ready[k] = 1'b0;
            exp_cnt[k]++;
        end
    endtask

    // one full access; lat is -1 when either handshake never happened
    task automatic xfer(input int k, input logic w, input logic b, input logic [17:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd, output logic er);
        int  acc, rv;
        bit  ok1, ok2;
        send_req(k, w, b, a, d, acc, ok1);
        ok2 = 1'b0;
        rv  = 0;
        rd  = 32'hxxxxxxxx;
        er  = 1'bx;
        if (ok1) recv_rsp(k, rv, rd, er, ok2);
        lat = (ok1 && ok2) ? (rv - acc) : -1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b1;
            req_write[k] = 1'b0;
            req_byte[k]  = 1'b0;
            req_addr[k]  = 18'h0;
            req_wdata[k] = 32'h0;
            rsp_ready[k] = 1'b0;
            exp_cnt[k]   = 16'd0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready_o[k] !== 1'b0) begin errors++; $display("FAIL reset_req_ready[%0d]: got %b want 0", k, req_ready_o[k]); end
            checks++; if (rsp_valid_o[k] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", k, rsp_valid_o[k]); end
            checks++; if ({rsp_rdata_o[k], rsp_err_o[k]} !== 33'd0) begin errors++; $display("FAIL reset_rsp_data[%0d]: got %h/%b want 0/0", k, rsp_rdata_o[k], rsp_err_o[k]); end
            checks++; if (count_o[k] !== 16'd0) begin errors++; $display("FAIL reset_count[%0d]: got %h want 0", k, count_o[k]); end
            req_valid[k] = 1'b0;
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready_o[0]); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'h0, 1'b0});
        xfer(0, 1'b1, 1'b0, 18'h00005, 32'hDEADBEEF, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 3) begin errors++; $display("FAIL word_store_latency: got %0d want 3", lat); end
        checks++; if ({rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL word_store_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        exp_q.push_back('{32'hDEADBEEF, 1'b0});
        xfer(0, 1'b0, 1'b0, 18'h00005, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 3) begin errors++; $display("FAIL word_load_latency: got %0d want 3", lat); end
        checks++; if ({rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL word_load_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        checks++; if (count_o[0] !== exp_cnt[0]) begin errors++; $display("FAIL word_count: got %h want %h", count_o[0], exp_cnt[0]); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic er; exp_t e;
        logic [31:0] exp_byte_load, exp_word_load;
`ifdef DMEM_BYTE_OPS_EN
        exp_byte_load = 32'hFFFFFFF0;
        exp_word_load = 32'h123456F0;
`else
        exp_byte_load = 32'h000000F0;
        exp_word_load = 32'h000000F0;
`endif
        exp_q.push_back('{32'h0, 1'b0});
        xfer(0, 1'b1, 1'b0, 18'h7, 32'h12345678, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 3 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL byte_preload: got lat %0d %h/%b want 3 %h/%b", lat, rd, er, e.rdata, e.err); end
        exp_q.push_back('{32'h0, 1'b0});
        xfer(0, 1'b1, 1'b1, 18'h7, 32'h000000F0, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 3 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL byte_store: got lat %0d %h/%b want 3 %h/%b", lat, rd, er, e.rdata, e.err); end
        exp_q.push_back('{exp_byte_load, 1'b0});
        xfer(0, 1'b0, 1'b1, 18'h7, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 3 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL byte_load: got lat %0d %h/%b want 3 %h/%b", lat, rd, er, e.rdata, e.err); end
        exp_q.push_back('{exp_word_load, 1'b0});
        xfer(0, 1'b0, 1'b0, 18'h7, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 3 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL byte_word_load: got lat %0d %h/%b want 3 %h/%b", lat, rd, er, e.rdata, e.err); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic er; exp_t e;
        logic [17:0] addr_t [6];
        logic        wr_t   [6];
        logic [31:0] wd_t   [6];
        exp_t        exp_t6 [6];
        addr_t = '{18'h00000, 18'h00400, 18'h00000, 18'h003FF, 18'h003FF, 18'h3FFFF};
        wr_t   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        wd_t   = '{32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0, 32'h0BADF00D, 32'h0, 32'h0};
        exp_t6 = '{'{32'h0, 1'b0}, '{32'h0, 1'b1}, '{32'hA5A5A5A5, 1'b0},
                   '{32'h0, 1'b0}, '{32'h0BADF00D, 1'b0}, '{32'h0, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exp_t6[i]);
            xfer(0, wr_t[i], 1'b0, addr_t[i], wd_t[i], lat, rd, er);
            e = exp_q.pop_front();
            checks++; if (lat !== 3 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL range_%0d addr %h: got lat %0d %h/%b want 3 %h/%b", i, addr_t[i], lat, rd, er, e.rdata, e.err); end
        end
        checks++; if (count_o[0] !== exp_cnt[0]) begin errors++; $display("FAIL range_count: got %h want %h", count_o[0], exp_cnt[0]); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'h0, 1'b0});
        xfer(1, 1'b1, 1'b0, 18'h9, 32'hCAFEF00D, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 1 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL bp_preload: got lat %0d %h/%b want 1 %h/%b", lat, rd, er, e.rdata, e.err); end

        exp_q.push_back('{32'hCAFEF00D, 1'b0});
        @(negedge clock);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_byte[1]  = 1'b0;
        req_addr[1]  = 18'h9;
        req_wdata[1] = 32'h0;
        checks++; if (req_ready_o[1] !== 1'b1) begin errors++; $display("FAIL bp_accept_ready: got %b want 1", req_ready_o[1]); end
        @(negedge clock);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1]} !== {1'b1, e.rdata, e.err}) begin errors++; $display("FAIL bp_hold_%0d: got %b %h/%b want 1 %h/%b", i, rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1], e.rdata, e.err); end
            checks++; if (req_ready_o[1] !== 1'b0) begin errors++; $display("FAIL bp_req_ready_%0d: got %b want 0", i, req_ready_o[1]); end
            @(negedge clock);
        end

        exp_q.push_back('{32'hCAFEF00D, 1'b0});
        rsp_ready[1] = 1'b1;
        @(negedge clock);
        rsp_ready[1] = 1'b0;
        exp_cnt[1]++;
        checks++; if ({rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1], req_ready_o[1]} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin errors++; $display("FAIL bp_turnaround: got v%b %h/%b rdy%b want v0 0/0 rdy1", rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1], req_ready_o[1]); end
        @(negedge clock);
        req_valid[1] = 1'b0;
        e = exp_q.pop_front();
        checks++; if ({rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1]} !== {1'b1, e.rdata, e.err}) begin errors++; $display("FAIL bp_second: got %b %h/%b want 1 %h/%b", rsp_valid_o[1], rsp_rdata_o[1], rsp_err_o[1], e.rdata, e.err); end
        rsp_ready[1] = 1'b1;
        @(negedge clock);
        rsp_ready[1] = 1'b0;
        exp_cnt[1]++;
        checks++; if (count_o[1] !== exp_cnt[1]) begin errors++; $display("FAIL bp_count: got %h want %h", count_o[1], exp_cnt[1]); end
    endtask

    task automatic test_reset_mid();
        int lat, acc, n; bit ok; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{32'h0, 1'b0});
        xfer(2, 1'b1, 1'b0, 18'h3, 32'h22222222, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 5 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL rst_preload: got lat %0d %h/%b want 5 %h/%b", lat, rd, er, e.rdata, e.err); end

        // store abandoned two cycles after its accept, well before its execute edge
        @(negedge clock);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_byte[2]  = 1'b0;
        req_addr[2]  = 18'h3;
        req_wdata[2] = 32'h11111111;
        checks++; if (req_ready_o[2] !== 1'b1) begin errors++; $display("FAIL rst_accept_ready: got %b want 1", req_ready_o[2]); end
        @(negedge clock);
        req_valid[2] = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if ({req_ready_o[2], rsp_valid_o[2], rsp_rdata_o[2], rsp_err_o[2], count_o[2]} !== 51'd0) begin errors++; $display("FAIL rst_mid_outputs: got rdy%b v%b %h/%b cnt%h want all 0", req_ready_o[2], rsp_valid_o[2], rsp_rdata_o[2], rsp_err_o[2], count_o[2]); end
        for (int k = 0; k < 3; k++) exp_cnt[k] = 16'd0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back('{32'h22222222, 1'b0});
        xfer(2, 1'b0, 1'b0, 18'h3, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 5 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL rst_abandoned_store: got lat %0d %h/%b want 5 %h/%b", lat, rd, er, e.rdata, e.err); end

        // store reset while its response is pending: the write already happened
        send_req(2, 1'b1, 1'b0, 18'h4, 32'h33333333, acc, ok);
        n = 0;
        while (!rsp_valid_o[2] && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++; if (!ok || rsp_valid_o[2] !== 1'b1) begin errors++; $display("FAIL rst_late_rsp_valid: got %b want 1", rsp_valid_o[2]); end
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if ({rsp_valid_o[2], rsp_rdata_o[2], rsp_err_o[2]} !== 34'd0) begin errors++; $display("FAIL rst_late_outputs: got v%b %h/%b want 0 0/0", rsp_valid_o[2], rsp_rdata_o[2], rsp_err_o[2]); end
        for (int k = 0; k < 3; k++) exp_cnt[k] = 16'd0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back('{32'h33333333, 1'b0});
        xfer(2, 1'b0, 1'b0, 18'h4, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        checks++; if (lat !== 5 || {rd, er} !== {e.rdata, e.err}) begin errors++; $display("FAIL rst_executed_store: got lat %0d %h/%b want 5 %h/%b", lat, rd, er, e.rdata, e.err); end
        checks++; if (count_o[2] !== exp_cnt[2]) begin errors++; $display("FAIL rst_count: got %h want %h", count_o[2], exp_cnt[2]); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_range();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the slave end of the processor's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then returns a response over a second valid/ready handshake. It replaces the zero-latency combinational memory so the core can be moved to a stalling, handshake-driven memory interface.

## Interface
Parameters:
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2: wait states between accept and response. Legal range 0..15.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_byte  input  1  byte operation, replacing a word operation.
- req_addr  input  18  word address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  address out of range.
- access_count  output  16  completed responses, wraps.

## Operation
- States: IDLE, WAIT, RESP. Reset puts the block in IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, register write, byte, addr and wdata, and load the 4-bit wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go to RESP. Otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, the access executes and the block goes to RESP.
  - Total WAIT occupancy is WAIT_CYCLES cycles.
- Access execution happens once, on the WAIT→RESP edge (or the IDLE→RESP edge if WAIT_CYCLES = 0):
  - Range check: captured addr ≥ 2^DEPTH_LOG2 → rsp_err = 1, no write, rsp_rdata = 0.
  - Word load: rsp_rdata = mem[addr].
  - Byte load: rsp_rdata = sign-extend(mem[addr][7:0]).
  - Word store: mem[addr] = wdata, rsp_rdata = 0.
  - Byte store: mem[addr][7:0] = wdata[7:0], bits [31:8] unchanged, rsp_rdata = 0.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable.
  - On rsp_ready: access_count increments (16-bit, FFFF→0000, errors included), then go to IDLE.
- req_ready = 0 in WAIT and RESP. Requests presented there are not accepted and must be held by the requester.
- Memory contents are not reset. Initial contents are undefined unless preloaded by the bench.

## Timing
- Reset values while reset_n = 0: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, access_count = 0.
- First accept is possible in the first cycle after reset_n rises.
- Latency from accept edge to rsp_valid = 1 is WAIT_CYCLES + 1 cycles.
- rsp_valid stays high until the rsp_ready handshake completes.
- req_ready rises the cycle after the response handshake. There is no same-cycle turnaround, so peak throughput is one access per WAIT_CYCLES + 2 cycles.
- All outputs are registered except req_ready, which is decoded from the state and gated by reset_n.
- Reset mid-operation:
  - Pending access is abandoned and the block returns to IDLE with reset values.
  - A store reset before its execute edge is not written.
  - A store reset after its execute edge remains written.
- rsp_rdata and rsp_err return to 0 when leaving RESP.

## Configuration
- DMEM_BYTE_OPS_EN defined: byte load/store behave as specified above.
- DMEM_BYTE_OPS_EN undefined:
  - req_byte is ignored and every access is a word access.
  - Byte-lane merge and sign-extension logic are not synthesized.

## Test plan
- Word store/load, WAIT_CYCLES = 2:
  - Stimulus: store addr 0x00005, data 0xDEADBEEF; then load addr 0x00005.
  - Response: each rsp_valid rises 3 cycles after its accept; the load returns 0xDEADBEEF with rsp_err = 0.
- Byte ops, DMEM_BYTE_OPS_EN defined:
  - Stimulus: mem[7] = 0x12345678; byte store wdata 0x000000F0; then byte load addr 7; then word load addr 7.
  - Response: byte load returns 0xFFFFFFF0; word load returns 0x123456F0.
- Byte ops, DMEM_BYTE_OPS_EN undefined:
  - Stimulus: same sequence as above.
  - Response: word load returns 0x000000F0.
- Out of range, DEPTH_LOG2 = 10:
  - Stimulus: store to addr 0x00400, then load addr 0x00000 (preloaded 0xA5A5A5A5).
  - Response: store reports rsp_err = 1 and rsp_rdata = 0; load returns 0xA5A5A5A5 unchanged; access_count = 2.
- Backpressure and WAIT_CYCLES = 0:
  - Stimulus: load accepted; hold rsp_ready = 0 for 5 cycles; keep req_valid high throughout.
  - Response: rsp_valid rises 1 cycle after accept; rsp_valid and data stay stable; req_ready stays 0 and the second request is accepted only after the handshake.
- Reset mid-WAIT, WAIT_CYCLES = 4:
  - Stimulus: store 0x11111111 to addr 3 (old value 0x22222222); assert reset_n = 0 two cycles after accept.
  - Response: all outputs return to reset values; a later load of addr 3 returns 0x22222222.
